job_dispatcher: RTL and testbench

// - Front end of the gate scheduler: queues host program IDs and initialises state memory to |0...0>.
// - Launches one scheduler run per job, waits for completion, then streams every amplitude plus the run cycle count back to the host.
// - Owns the state-memory host port via mem_sel; the scheduler owns memory whenever mem_sel=0.

---
 rtl/job_dispatcher.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_job_dispatcher.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/job_dispatcher.sv
// rtl/job_dispatcher.sv - job queue, |0..0> state init, scheduler launch and amplitude readout (option: SCHED_WATCHDOG_EN)
module job_dispatcher #(
    parameter int N_QUBITS    = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int ONE_VAL     = 16384,
    parameter int WDOG_CYCLES = 65536,
    localparam int DIM        = 1 << N_QUBITS,
    localparam int AW         = $clog2(DIM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [2:0]           job_prog_id,
    output logic                 sched_start,
    output logic [2:0]           sched_prog_id,
    input  logic                 sched_done,
    input  logic [31:0]          sched_cycles,
    output logic                 mem_sel,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic signed [15:0]   mem_din_r,
    output logic signed [15:0]   mem_din_i,
    input  logic signed [15:0]   mem_dout_r,
    input  logic signed [15:0]   mem_dout_i,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic signed [15:0]   res_data_r,
    output logic signed [15:0]   res_data_i,
    output logic [AW-1:0]        res_idx,
    output logic                 res_last,
    output logic [31:0]          res_cycles,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_READ   = 3'd4;
    localparam logic [2:0] S_STREAM = 3'd5;
    localparam logic [2:0] S_POP    = 3'd6;

    localparam logic [AW-1:0]      IDX_LAST = AW'(DIM - 1);
    localparam logic [PW:0]        FULL_CNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic signed [15:0] ONE      = 16'(ONE_VAL);

    logic [2:0]         fifo_q [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PW:0]        count_q, count_d;
    logic               push, pop;

    logic [2:0]         state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic               rd_phase_q, rd_phase_d;
    logic               armed_q, armed_d;
    logic               job_ready_q, job_ready_d;
    logic               sched_start_q, sched_start_d;
    logic [2:0]         sched_prog_id_q, sched_prog_id_d;
    logic               mem_sel_q, mem_sel_d;
    logic               mem_we_q, mem_we_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic signed [15:0] mem_din_r_q, mem_din_r_d, mem_din_i_q, mem_din_i_d;
    logic               res_valid_q, res_valid_d;
    logic signed [15:0] res_data_r_q, res_data_r_d, res_data_i_q, res_data_i_d;
    logic [AW-1:0]      res_idx_q, res_idx_d;
    logic               res_last_q, res_last_d;
    logic [31:0]        res_cycles_q, res_cycles_d;
    logic               busy_q, busy_d;

`ifdef SCHED_WATCHDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
    logic [31:0]        wdog_q, wdog_d;
    logic               err_timeout_q, err_timeout_d;
`else
    logic               unused_wdog;
    assign unused_wdog = (WDOG_CYCLES != 0);
`endif

    // Ready comes from the registered count, so a pop frees its slot one cycle later.
    assign push    = job_valid && job_ready_q;
    assign count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

    // Job queue payload storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= job_prog_id;
    end

    // Job queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Next-state and next-output logic for the job lifecycle.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        rd_phase_d      = rd_phase_q;
        armed_d         = armed_q;
        sched_start_d   = 1'b0;
        sched_prog_id_d = sched_prog_id_q;
        mem_sel_d       = mem_sel_q;
        mem_we_d        = 1'b0;
        mem_addr_d      = mem_addr_q;
        mem_din_r_d     = 16'sd0;
        mem_din_i_d     = 16'sd0;
        res_valid_d     = res_valid_q;
        res_data_r_d    = res_data_r_q;
        res_data_i_d    = res_data_i_q;
        res_idx_d       = res_idx_q;
        res_last_d      = res_last_q;
        res_cycles_d    = res_cycles_q;
        pop             = 1'b0;
`ifdef SCHED_WATCHDOG_EN
        wdog_d          = wdog_q;
        err_timeout_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d     = S_INIT;
                    idx_d       = '0;
                    mem_sel_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = '0;
                    mem_din_r_d = ONE;
                end
            end
            S_INIT: begin
                if (idx_q == IDX_LAST) begin
                    state_d         = S_LAUNCH;
                    mem_sel_d       = 1'b0;
                    sched_start_d   = 1'b1;
                    sched_prog_id_d = fifo_q[rd_ptr_q];
                    armed_d         = 1'b0;
                end else begin
                    idx_d      = idx_q + 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = idx_q + 1'b1;
                end
            end
            S_LAUNCH: begin
                state_d = S_RUN;
                armed_d = 1'b0;
`ifdef SCHED_WATCHDOG_EN
                wdog_d  = '0;
`endif
            end
            S_RUN: begin
                // A done level left over from the previous job is ignored until
                // the scheduler has been seen low at least once.
                if (sched_done && armed_q) begin
                    state_d      = S_READ;
                    res_cycles_d = sched_cycles;
                    mem_sel_d    = 1'b1;
                    idx_d        = '0;
                    mem_addr_d   = '0;
                    rd_phase_d   = 1'b0;
                end else begin
                    if (!sched_done) armed_d = 1'b1;
`ifdef SCHED_WATCHDOG_EN
                    wdog_d = wdog_q + 32'd1;
                    if (wdog_q == WDOG_LAST) begin
                        err_timeout_d = 1'b1;
                        state_d       = S_POP;
                    end
`endif
                end
            end
            S_READ: begin
                // Phase 0 presents the address; the synchronous RAM answers in phase 1.
                if (!rd_phase_q) begin
                    rd_phase_d = 1'b1;
                end else begin
                    rd_phase_d   = 1'b0;
                    res_valid_d  = 1'b1;
                    res_data_r_d = mem_dout_r;
                    res_data_i_d = mem_dout_i;
                    res_idx_d    = idx_q;
                    res_last_d   = (idx_q == IDX_LAST);
                    state_d      = S_STREAM;
                end
            end
            S_STREAM: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    if (idx_q == IDX_LAST) begin
                        state_d   = S_POP;
                        mem_sel_d = 1'b0;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        mem_addr_d = idx_q + 1'b1;
                        state_d    = S_READ;
                    end
                end
            end
            S_POP: begin
                pop     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d      = (state_d != S_IDLE);
        job_ready_d = (count_d != FULL_CNT);
    end

    // State and registered outputs; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            rd_phase_q      <= 1'b0;
            armed_q         <= 1'b0;
            job_ready_q     <= 1'b1;
            sched_start_q   <= 1'b0;
            sched_prog_id_q <= '0;
            mem_sel_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_din_r_q     <= '0;
            mem_din_i_q     <= '0;
            res_valid_q     <= 1'b0;
            res_data_r_q    <= '0;
            res_data_i_q    <= '0;
            res_idx_q       <= '0;
            res_last_q      <= 1'b0;
            res_cycles_q    <= '0;
            busy_q          <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
            wdog_q          <= '0;
            err_timeout_q   <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            rd_phase_q      <= rd_phase_d;
            armed_q         <= armed_d;
            job_ready_q     <= job_ready_d;
            sched_start_q   <= sched_start_d;
            sched_prog_id_q <= sched_prog_id_d;
            mem_sel_q       <= mem_sel_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_din_r_q     <= mem_din_r_d;
            mem_din_i_q     <= mem_din_i_d;
            res_valid_q     <= res_valid_d;
            res_data_r_q    <= res_data_r_d;
            res_data_i_q    <= res_data_i_d;
            res_idx_q       <= res_idx_d;
            res_last_q      <= res_last_d;
            res_cycles_q    <= res_cycles_d;
            busy_q          <= busy_d;
`ifdef SCHED_WATCHDOG_EN
            wdog_q          <= wdog_d;
            err_timeout_q   <= err_timeout_d;
`endif
        end
    end

    assign job_ready     = job_ready_q;
    assign sched_start   = sched_start_q;
    assign sched_prog_id = sched_prog_id_q;
    assign mem_sel       = mem_sel_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_din_r     = mem_din_r_q;
    assign mem_din_i     = mem_din_i_q;
    assign res_valid     = res_valid_q;
    assign res_data_r    = res_data_r_q;
    assign res_data_i    = res_data_i_q;
    assign res_idx       = res_idx_q;
    assign res_last      = res_last_q;
    assign res_cycles    = res_cycles_q;
    assign busy          = busy_q;
`ifdef SCHED_WATCHDOG_EN
    assign err_timeout   = err_timeout_q;
`else
    assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_job_dispatcher.sv
// tb/tb_job_dispatcher.sv - randomized self-checking bench for job_dispatcher
module tb_job_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_valid;
    logic        job_ready;
    logic [2:0]  job_prog_id;
    logic        sched_start;
    logic [2:0]  sched_prog_id;
    logic        sched_done;
    logic [31:0] sched_cycles;
    logic        mem_sel;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [15:0] mem_din_r, mem_din_i;
    logic [15:0] mem_dout_r, mem_dout_i;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data_r, res_data_i;
    logic [3:0]  res_idx;
    logic        res_last;
    logic [31:0] res_cycles;
    logic        busy;
    logic        err_timeout;

    // Scheduler-side write port into the bench RAM.
    logic        sw_en;
    logic [3:0]  sw_addr;
    logic [15:0] sw_r, sw_i;

    logic [15:0] mem_r [16];
    logic [15:0] mem_i [16];
    logic [15:0] exp_r [16];
    logic [15:0] exp_i [16];
    logic [2:0]  model_q [$];

    int init_wr   = 0;
    int start_cnt = 0;
    int n_chk     = 0;
    int n_err     = 0;

    job_dispatcher #(.WDOG_CYCLES(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready), .job_prog_id(job_prog_id),
        .sched_start(sched_start), .sched_prog_id(sched_prog_id),
        .sched_done(sched_done), .sched_cycles(sched_cycles),
        .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din_r(mem_din_r), .mem_din_i(mem_din_i),
        .mem_dout_r(mem_dout_r), .mem_dout_i(mem_dout_i),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data_r(res_data_r), .res_data_i(res_data_i),
        .res_idx(res_idx), .res_last(res_last), .res_cycles(res_cycles),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // State memory with synchronous read, shared between dispatcher and scheduler mock.
    always @(posedge clk) begin
        if (mem_sel && mem_we) begin
            mem_r[mem_addr] <= mem_din_r;
            mem_i[mem_addr] <= mem_din_i;
        end else if (!mem_sel && sw_en) begin
            mem_r[sw_addr] <= sw_r;
            mem_i[sw_addr] <= sw_i;
        end
        mem_dout_r <= mem_r[mem_addr];
        mem_dout_i <= mem_i[mem_addr];
        if (sched_start) init_wr <= 0;
        else if (mem_sel && mem_we) init_wr <= init_wr + 1;
        if (sched_start) start_cnt <= start_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_job(input logic [2:0] id);
        job_valid   = 1'b1;
        job_prog_id = id;
        check("job_ready", 64'(job_ready), 64'(model_q.size() < 4));
        if (model_q.size() < 4) model_q.push_back(id);
        tick();
        job_valid = 1'b0;
    endtask

    task automatic run_job(input int stale_len, input int done_dly, input logic [31:0] cyc,
                           input int bp_idx, input int abort_at);
        int n;
        int viol;
        int s0;
        logic [2:0]  exp_id;
        logic [15:0] hr, hi;
        exp_id = model_q[0];
        s0 = start_cnt;
        n = 0;
        while (!sched_start && n < 300) begin tick(); n++; end
        check("launch_seen", 64'(sched_start), 64'd1);
        check("prog_id", 64'(sched_prog_id), 64'(exp_id));
        check("init_writes", 64'(init_wr), 64'd16);
        viol = 0;
        for (int i = 0; i < 16; i++) begin
            exp_r[i] = (i == 0) ? 16'd16384 : 16'd0;
            exp_i[i] = 16'd0;
            if (mem_r[i] !== exp_r[i] || mem_i[i] !== exp_i[i]) viol++;
        end
        check("init_image", 64'(viol), 64'd0);
        viol = 0;
        for (int t = 0; t < done_dly; t++) begin
            sched_done   = (t < stale_len);
            sched_cycles = $urandom;
            if (t < 16) begin
                sw_en = 1'b1; sw_addr = 4'(t);
                sw_r = 16'($urandom); sw_i = 16'($urandom);
                exp_r[t] = sw_r; exp_i[t] = sw_i;
            end else begin
                sw_en = 1'b0;
            end
            tick();
            if (t == 0) check("start_pulse", 64'(sched_start), 64'd0);
            if (mem_sel || res_valid) viol++;
        end
        check("run_hold", 64'(viol), 64'd0);
        sw_en = 1'b0;
        sched_done = 1'b1;
        sched_cycles = cyc;
        for (int b = 0; b < 16; b++) begin
            n = 0;
            while (!res_valid && n < 20) begin tick(); n++; end
            check("beat_valid", 64'(res_valid), 64'd1);
            check("beat_idx", 64'(res_idx), 64'(b));
            check("beat_data", 64'({res_data_r, res_data_i}), 64'({exp_r[b], exp_i[b]}));
            check("beat_last", 64'(res_last), 64'(b == 15));
            if (b == abort_at) begin
                rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_res_valid", 64'(res_valid), 64'd0);
                check("rst_start", 64'(sched_start), 64'd0);
                check("rst_mem_sel", 64'(mem_sel), 64'd0);
                check("rst_job_ready", 64'(job_ready), 64'd1);
                model_q.delete();
                sched_done = 1'b0;
                return;
            end
            if (b == bp_idx) begin
                hr = res_data_r; hi = res_data_i; viol = 0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    if (!res_valid || res_idx !== 4'(b) || res_data_r !== hr || res_data_i !== hi) viol++;
                end
                check("bp_hold", 64'(viol), 64'd0);
            end else begin
                repeat ($urandom_range(0, 2)) tick();
            end
            res_ready = 1'b1; tick(); res_ready = 1'b0;
        end
        check("res_cycles", 64'(res_cycles), 64'(cyc));
        check("after_last", 64'(res_valid), 64'd0);
        check("one_start", 64'(start_cnt - s0), 64'd1);
        void'(model_q.pop_front());
    endtask

    initial begin
        rst_n = 1'b0; job_valid = 1'b0; job_prog_id = '0; sched_done = 1'b0;
        sched_cycles = '0; res_ready = 1'b0; sw_en = 1'b0; sw_addr = '0; sw_r = '0; sw_i = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_job_ready", 64'(job_ready), 64'd1);
        check("reset_res_valid", 64'(res_valid), 64'd0);
        check("reset_mem_sel", 64'(mem_sel), 64'd0);
        check("reset_err", 64'(err_timeout), 64'd0);

        for (int i = 0; i < 16; i++) begin
            sw_en = 1'b1; sw_addr = 4'(i); sw_r = 16'($urandom); sw_i = 16'($urandom);
            tick();
        end
        sw_en = 1'b0;

        push_job(3'd2);
        run_job(0, 10, 32'd123, 3, -1);

        push_job(3'd3);
        run_job(3, 20, $urandom, -1, -1);

        for (int i = 1; i <= 4; i++) push_job(3'(i));
        push_job(3'd5);
        for (int i = 0; i < 4; i++) run_job(0, $urandom_range(10, 20), $urandom, -1, -1);

        for (int i = 0; i < 3; i++) begin
            push_job(3'($urandom));
            run_job($urandom_range(0, 2), $urandom_range(10, 20), $urandom, -1, -1);
        end

        push_job(3'd6);
        run_job(0, 12, 32'd77, -1, 3);

`ifdef SCHED_WATCHDOG_EN
        begin
            int n;
            int seen;
            int viol;
            push_job(3'd7);
            n = 0;
            while (!sched_start && n < 300) begin tick(); n++; end
            check("wd_launch", 64'(sched_start), 64'd1);
            seen = -1; viol = 0;
            for (int t = 1; t <= 40; t++) begin
                tick();
                if (err_timeout && seen < 0) seen = t;
                if (res_valid) viol++;
            end
            check("wd_pulse", 64'(seen >= 32 && seen <= 33), 64'd1);
            check("wd_no_beats", 64'(viol), 64'd0);
            void'(model_q.pop_front());
            push_job(3'd1);
            run_job(0, 12, 32'd5, -1, -1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
